// File: rtl/sel_mode_if.sv
// Key-event inputs and mode/speed outputs of the mode selector, grouped for port binding.
// key_flag is a one-cycle valid with no ready: the selector always accepts the event in the cycle it is flagged.
interface sel_mode_if #(
  parameter int NUM_KEYS = 4
);
  localparam int MODE_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] key_value;
  logic [NUM_KEYS-1:0] key_flag;
  logic [MODE_W-1:0]   sel_type;
  logic [NUM_KEYS-2:0] sel_pwm;
  logic                mode_chg;
  logic                pwm_chg;
  logic                armed;

  modport master (
    output key_value, key_flag,
    input  sel_type, sel_pwm, mode_chg, pwm_chg, armed
  );

  modport slave (
    input  key_value, key_flag,
    output sel_type, sel_pwm, mode_chg, pwm_chg, armed
  );
endinterface

// File: rtl/sel_mode_ctrl.sv
// Key-chord mode selector: key 0 is a shift key that opens a chord window; other keys pick a
// drive mode (alone) or a one-hot speed level (chorded with key 0).
module sel_mode_ctrl #(
  parameter int NUM_KEYS     = 4,
  parameter int CHORD_CYC    = 5000000,
  parameter int DEFAULT_MODE = 0,
  parameter int DEFAULT_PWM  = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  sel_mode_if.slave bus
);
  localparam int MODE_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
  localparam int PWM_W  = NUM_KEYS - 1;
  localparam int CNT_W  = $clog2(CHORD_CYC);

  localparam logic [MODE_W-1:0] MODE_RST = MODE_W'(DEFAULT_MODE);
  localparam logic [PWM_W-1:0]  PWM_RST  = PWM_W'(1) << DEFAULT_PWM;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHORD_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [MODE_W-1:0]   sel_type_q, type_nx;
  logic [PWM_W-1:0]    sel_pwm_q, pwm_nx;
  logic                mode_chg_q, pwm_chg_q;

  logic [NUM_KEYS-1:0] press;
  logic                hi_press;
  logic [MODE_W-1:0]   hi_idx;
  logic [PWM_W-1:0]    hi_onehot;

  assign press    = bus.key_flag & ~bus.key_value;
  assign hi_press = |press[NUM_KEYS-1:1];

  // Scan from the top down so the lowest pressed key among 1..N-1 is the last one written.
  always_comb begin
    hi_idx    = '0;
    hi_onehot = '0;
    for (int i = NUM_KEYS - 1; i >= 1; i--) begin
      if (press[i]) begin
        hi_idx         = MODE_W'(i);
        hi_onehot      = '0;
        hi_onehot[i-1] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    type_nx  = sel_type_q;
    pwm_nx   = sel_pwm_q;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (hi_press) begin
          if (press[0]) pwm_nx  = hi_onehot;
          else          type_nx = hi_idx;
        end else if (press[0]) begin
          state_nx = ARMED;
        end
      end
      ARMED: begin
        // A press on the final window cycle wins over the mode-0 timeout.
        if (hi_press) begin
          pwm_nx   = hi_onehot;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (press[0]) begin
          cnt_nx = '0;
        end else if (cnt == CNT_LAST) begin
          type_nx  = '0;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_type_q <= MODE_RST;
      sel_pwm_q  <= PWM_RST;
      mode_chg_q <= 1'b0;
      pwm_chg_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel_type_q <= type_nx;
      sel_pwm_q  <= pwm_nx;
      mode_chg_q <= (type_nx != sel_type_q);
      pwm_chg_q  <= (pwm_nx != sel_pwm_q);
    end
  end

  assign bus.sel_type = sel_type_q;
  assign bus.sel_pwm  = sel_pwm_q;
  assign bus.mode_chg = mode_chg_q;
  assign bus.pwm_chg  = pwm_chg_q;
  assign bus.armed    = (state == ARMED);
endmodule

// File: tb/tb_sel_mode_ctrl.sv
// Bench for sel_mode_ctrl: reference model feeds an expected-output queue checked every cycle,
// plus directed checks on window length, strobe counts and reset behaviour.
module tb_sel_mode_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   mc_cnt;
  int   pc_cnt;
  int   arm_cnt;

  logic [W-1:0] exp_q[$];

  logic [1:0] m_type;
  logic [2:0] m_pwm;
  logic       m_arm;
  int         m_cnt;

  sel_mode_if #(.NUM_KEYS(4)) bus ();

  sel_mode_ctrl #(
    .NUM_KEYS    (4),
    .CHORD_CYC   (8),
    .DEFAULT_MODE(0),
    .DEFAULT_PWM (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: one expected output word per sampled clock edge
  initial begin
    logic [3:0] p;
    logic [1:0] nt;
    logic [2:0] np;
    logic       na;
    int         nc;
    int         j;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_type = 2'd0;
        m_pwm  = 3'b010;
        m_arm  = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
      end else begin
        p  = bus.key_flag & ~bus.key_value;
        nt = m_type;
        np = m_pwm;
        na = m_arm;
        nc = m_cnt;
        j  = 0;
        for (int i = 3; i >= 1; i--) if (p[i]) j = i;
        if (j != 0) begin
          if (m_arm || p[0]) np = 3'b001 << (j - 1);
          else               nt = 2'(j);
          na = 1'b0;
          nc = 0;
        end else if (p[0]) begin
          na = 1'b1;
          nc = 0;
        end else if (m_arm) begin
          if (m_cnt == 7) begin
            nt = 2'd0;
            na = 1'b0;
            nc = 0;
          end else begin
            nc = m_cnt + 1;
          end
        end
        exp_q.push_back({nt, np, nt != m_type, np != m_pwm, na});
        m_type = nt;
        m_pwm  = np;
        m_arm  = na;
        m_cnt  = nc;
      end
    end
  end

  // scoreboard / monitor on the inactive edge
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      act = {bus.sel_type, bus.sel_pwm, bus.mode_chg, bus.pwm_chg, bus.armed};
      if (!rst_n) begin
        check("in_reset", act, 8'b00_010_0_0_0);
      end else if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("cycle", act, exp);
      end
      if (bus.mode_chg) mc_cnt++;
      if (bus.pwm_chg)  pc_cnt++;
      if (bus.armed)    arm_cnt++;
    end
  end

  // driver tasks: inputs change on the falling edge, tasks return 1 time unit after it
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    bus.key_flag  = mask;
    bus.key_value = ~mask;
    @(negedge clk);
    bus.key_flag  = 4'b0000;
    bus.key_value = 4'b1111;
    #1;
  endtask

  task automatic rel(input logic [3:0] mask);
    @(negedge clk);
    bus.key_flag  = mask;
    bus.key_value = 4'b1111;
    @(negedge clk);
    bus.key_flag  = 4'b0000;
    #1;
  endtask

  task automatic clr_cnt();
    mc_cnt  = 0;
    pc_cnt  = 0;
    arm_cnt = 0;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.key_value = 4'b1111;
    bus.key_flag  = 4'b0000;
    clr_cnt();

    // 1: reset values, then a quiet idle stretch
    wait_cyc(3);
    check("rst_type", bus.sel_type, 2'd0);
    check("rst_pwm", bus.sel_pwm, 3'b010);
    #1 rst_n = 1'b1;
    clr_cnt();
    wait_cyc(20);
    check("idle_mc", mc_cnt, 0);
    check("idle_pc", pc_cnt, 0);
    check("idle_arm", arm_cnt, 0);

    // 2: direct mode select, re-select, release event
    clr_cnt();
    press(4'b0100);
    check("m2_type", bus.sel_type, 2'd2);
    wait_cyc(2);
    check("m2_mc", mc_cnt, 1);
    clr_cnt();
    press(4'b0100);
    wait_cyc(2);
    check("m2_again_mc", mc_cnt, 0);
    rel(4'b0010);
    wait_cyc(2);
    check("rel_type", bus.sel_type, 2'd2);
    check("rel_mc", mc_cnt, 0);

    // 3: lone key0 times out to mode 0, then a window restart
    press(4'b1000);
    check("m3_type", bus.sel_type, 2'd3);
    clr_cnt();
    press(4'b0001);
    wait_cyc(7);
    check("win_open_arm", bus.armed, 1'b1);
    check("win_open_type", bus.sel_type, 2'd3);
    wait_cyc(1);
    check("timeout_type", bus.sel_type, 2'd0);
    check("timeout_arm", bus.armed, 1'b0);
    wait_cyc(4);
    check("timeout_armcnt", arm_cnt, 8);
    check("timeout_mc", mc_cnt, 1);
    press(4'b1000);
    clr_cnt();
    press(4'b0001);
    wait_cyc(4);
    press(4'b0001);
    wait_cyc(7);
    check("restart_arm", bus.armed, 1'b1);
    check("restart_type", bus.sel_type, 2'd3);
    wait_cyc(1);
    check("restart_commit", bus.sel_type, 2'd0);
    wait_cyc(4);
    check("restart_armcnt", arm_cnt, 14);
    check("restart_mc", mc_cnt, 1);

    // 4: key0 then key3 inside the window -> speed, no mode-0 commit
    press(4'b0100);
    clr_cnt();
    press(4'b0001);
    wait_cyc(2);
    press(4'b1000);
    check("chord_pwm", bus.sel_pwm, 3'b100);
    check("chord_type", bus.sel_type, 2'd2);
    check("chord_arm", bus.armed, 1'b0);
    wait_cyc(12);
    check("chord_mc", mc_cnt, 0);
    check("chord_pc", pc_cnt, 1);
    check("chord_type_hold", bus.sel_type, 2'd2);

    // 5: simultaneous presses in IDLE
    press(4'b1010);
    check("prio_type", bus.sel_type, 2'd1);
    clr_cnt();
    press(4'b0011);
    wait_cyc(3);
    check("same_cyc_pwm", bus.sel_pwm, 3'b001);
    check("same_cyc_arm", arm_cnt, 0);
    check("same_cyc_pc", pc_cnt, 1);

    // 6: reset inside an open window
    press(4'b0001);
    wait_cyc(3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_type", bus.sel_type, 2'd0);
    check("mid_rst_pwm", bus.sel_pwm, 3'b010);
    check("mid_rst_arm", bus.armed, 1'b0);
    wait_cyc(2);
    #1 rst_n = 1'b1;
    clr_cnt();
    wait_cyc(16);
    check("post_rst_mc", mc_cnt, 0);
    check("post_rst_arm", arm_cnt, 0);
    check("post_rst_type", bus.sel_type, 2'd0);

    // random key traffic, checked cycle by cycle against the model
    for (int k = 0; k < 60; k++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) rel(mask);
      else                           press(mask);
      wait_cyc($urandom_range(0, 10));
    end
    wait_cyc(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
